// File: rtl/dcc_pkg.sv
// Shared constants, FSM state encoding and sample formatting for the DAC streaming transmitter.
package dcc_pkg;
  localparam int DAC_W = 14;
  localparam int PAIR_W = 2 * DAC_W;
  localparam logic [DAC_W-1:0] DAC_MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_STARVE = 2'd3
  } dac_state_e;

  // Two's complement maps onto offset binary by flipping the sign bit.
  function automatic logic [DAC_W-1:0] to_offset_bin(input logic [DAC_W-1:0] s, input logic tc);
    return tc ? {~s[DAC_W-1], s[DAC_W-2:0]} : s;
  endfunction
endpackage

// File: rtl/dac_stream_tx_if.sv
// Sample-pair write stream. A pair transfers on a rising sys_clk edge where s_valid && s_ready;
// the source holds s_valid and data stable until then, and ready never depends on valid.
interface dac_stream_tx_if;
  import dcc_pkg::*;

  logic             s_valid;
  logic [DAC_W-1:0] s_data_a;
  logic [DAC_W-1:0] s_data_b;
  logic             s_ready;

  modport master (output s_valid, s_data_a, s_data_b, input s_ready);
  modport slave  (input s_valid, s_data_a, s_data_b, output s_ready);
endinterface

// File: rtl/dac_sample_fifo.sv
// Synchronous sample-pair FIFO with registered read data; the storage array carries no reset so it maps to block RAM.
module dac_sample_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 28
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
    if (rd_ok) rd_data <= mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/dac_stream_tx.sv
// Buffered two-channel DAC player: primes a sample FIFO, then plays pairs at a programmable rate,
// converting to offset binary with a two-stage read/format pipeline.
module dac_stream_tx
  import dcc_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int PRIME_LEVEL = 64
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  dac_stream_tx_if.slave         stream,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            rate_div,
  input  logic                   twos_comp,
  output logic [DAC_W-1:0]       DA,
  output logic [DAC_W-1:0]       DB,
  output logic                   active,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level,
  output dac_state_e             state
);
  localparam int LW = $clog2(DEPTH) + 1;

  dac_state_e        next_state;
  logic              ready_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic              prime_ok;
  logic              strobe;
  logic              pop;
  logic              pop_d1;
  logic              starve_hit;
  logic [15:0]       div_cnt;
  logic [15:0]       rate_q;
  logic [PAIR_W-1:0] rd_data;

  // ready_en keeps s_ready low through reset and raises it on the first clock afterwards.
  assign stream.s_ready = ready_en && !fifo_full;
  assign prime_ok       = (level >= LW'(PRIME_LEVEL));

  dac_sample_fifo #(.DEPTH(DEPTH), .W(PAIR_W)) u_fifo (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .wr_en   (stream.s_valid && stream.s_ready),
    .wr_data ({stream.s_data_a, stream.s_data_b}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (start)      next_state = ST_PRIME;
        ST_PRIME:  if (prime_ok)   next_state = ST_PLAY;
        ST_PLAY:   if (starve_hit) next_state = ST_STARVE;
        ST_STARVE: if (prime_ok)   next_state = ST_PLAY;
        default:                   next_state = ST_IDLE;
      endcase
    end
  end

  // A pop is withheld on a stop cycle so the entry survives in the FIFO.
  always_comb begin
    active     = 1'b0;
    strobe     = 1'b0;
    pop        = 1'b0;
    starve_hit = 1'b0;
    if (state == ST_PLAY) begin
      active     = 1'b1;
      strobe     = (div_cnt == 16'd0);
      pop        = strobe && !fifo_empty && !stop;
      starve_hit = strobe && fifo_empty;
    end
  end

  // Divider sits at zero outside PLAY so the first strobe lands on the first PLAY cycle.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      div_cnt  <= '0;
      rate_q   <= '0;
      underrun <= 1'b0;
      pop_d1   <= 1'b0;
      DA       <= DAC_MIDSCALE;
      DB       <= DAC_MIDSCALE;
    end else begin
      ready_en <= 1'b1;
      if (!active)     div_cnt <= '0;
      else if (strobe) div_cnt <= rate_q;
      else             div_cnt <= div_cnt - 16'd1;
      if (state == ST_IDLE && start && !stop) rate_q <= rate_div;
      if (start)           underrun <= 1'b0;
      else if (starve_hit) underrun <= 1'b1;
      pop_d1 <= pop;
      if (stop || state == ST_IDLE) begin
        DA <= DAC_MIDSCALE;
        DB <= DAC_MIDSCALE;
      end else if (pop_d1) begin
        DA <= to_offset_bin(rd_data[PAIR_W-1:DAC_W], twos_comp);
        DB <= to_offset_bin(rd_data[DAC_W-1:0], twos_comp);
      end
    end
  end
endmodule

// File: tb/tb_dac_stream_tx.sv
// Self-checking bench for dac_stream_tx: scenario tasks with an expected-pair queue filled on write
// and drained when the output pipeline delivers.
module tb_dac_stream_tx;
  import dcc_pkg::*;

  localparam int DEPTH = 256;
  localparam int PRIME_LEVEL = 8;
  localparam int LW = 9;

  logic             sys_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [15:0]      rate_div = '0;
  logic             twos_comp = 1'b0;
  logic [13:0]      DA, DB;
  logic             active, underrun;
  logic [LW-1:0]    level;
  dac_state_e       state;

  int n_checks = 0;
  int n_pass = 0;
  logic [27:0] exp_q[$];

  dac_stream_tx_if bus();

  dac_stream_tx #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .stream    (bus),
    .start     (start),
    .stop      (stop),
    .rate_div  (rate_div),
    .twos_comp (twos_comp),
    .DA        (DA),
    .DB        (DB),
    .active    (active),
    .underrun  (underrun),
    .level     (level),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] model_fmt(input logic [13:0] s, input logic tc);
    return tc ? (s ^ 14'h2000) : s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.s_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push_pair(input logic [13:0] a, input logic [13:0] b, input logic tc);
    bus.s_valid = 1'b1;
    bus.s_data_a = a;
    bus.s_data_b = b;
    exp_q.push_back({model_fmt(a, tc), model_fmt(b, tc)});
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] rd, input logic tc);
    rate_div = rd;
    twos_comp = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_active();
    for (int i = 0; i < 40; i++) begin
      if (active === 1'b1) break;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.s_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    n_checks++; if (DA !== 14'h2000) $display("FAIL rst_da: got %h want 2000", DA); else n_pass++;
    n_checks++; if (DB !== 14'h2000) $display("FAIL rst_db: got %h want 2000", DB); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (level !== 9'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.s_ready); else n_pass++;
    n_checks++; if (state !== ST_IDLE) $display("FAIL rst_state: got %0d want IDLE", state); else n_pass++;
    reset_n = 1'b1;
    n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL rst_ready_hold: got %b want 0", bus.s_ready); else n_pass++;
    tick();
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL rst_ready_rise: got %b want 1", bus.s_ready); else n_pass++;
  endtask

  task automatic test_stream();
    logic [13:0] a;
    logic [27:0] e;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      a = 14'(i);
      push_pair(a, ~a, 1'b0);
    end
    n_checks++; if (level !== 9'd64) $display("FAIL stream_level: got %0d want 64", level); else n_pass++;
    pulse_start(16'd0, 1'b0);
    tick();
    n_checks++; if (active !== 1'b1) $display("FAIL stream_play_entry: got %b want 1", active); else n_pass++;
    n_checks++; if (DA !== 14'h2000) $display("FAIL stream_da_c0: got %h want 2000", DA); else n_pass++;
    tick();
    n_checks++; if (DA !== 14'h2000) $display("FAIL stream_da_c1: got %h want 2000", DA); else n_pass++;
    e = {14'h2000, 14'h2000};
    for (int k = 0; k < 64; k++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({DA, DB} !== e) $display("FAIL stream_out[%0d]: got %h/%h want %h/%h", k, DA, DB, e[27:14], e[13:0]); else n_pass++;
    end
    tick();
    n_checks++; if (underrun !== 1'b1) $display("FAIL stream_underrun: got %b want 1", underrun); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL stream_starve_active: got %b want 0", active); else n_pass++;
    n_checks++; if ({DA, DB} !== e) $display("FAIL stream_hold: got %h/%h want %h/%h", DA, DB, e[27:14], e[13:0]); else n_pass++;
    pulse_stop();
    n_checks++; if (DA !== 14'h2000) $display("FAIL stream_stop_da: got %h want 2000", DA); else n_pass++;
    n_checks++; if (underrun !== 1'b1) $display("FAIL stream_underrun_sticky: got %b want 1", underrun); else n_pass++;
  endtask

  task automatic test_rate_div();
    logic [27:0] cur;
    logic exp_act, exp_uf;
    do_reset();
    for (int i = 0; i < 10; i++) push_pair(14'(i), 14'($urandom_range(0, 16383)), 1'b0);
    pulse_start(16'd3, 1'b0);
    cur = {14'h2000, 14'h2000};
    for (int c = 0; c <= 45; c++) begin
      tick();
      exp_act = (c <= 40);
      exp_uf = (c >= 41);
      if (c >= 2 && ((c - 2) % 4) == 0 && (c - 2) < 40) cur = exp_q.pop_front();
      n_checks++; if ({DA, DB} !== cur) $display("FAIL rate_out[c%0d]: got %h/%h want %h/%h", c, DA, DB, cur[27:14], cur[13:0]); else n_pass++;
      n_checks++; if (active !== exp_act) $display("FAIL rate_active[c%0d]: got %b want %b", c, active, exp_act); else n_pass++;
      n_checks++; if (underrun !== exp_uf) $display("FAIL rate_underrun[c%0d]: got %b want %b", c, underrun, exp_uf); else n_pass++;
    end
    n_checks++; if (DA !== 14'd9) $display("FAIL rate_last_da: got %h want 0009", DA); else n_pass++;
    pulse_start(16'd3, 1'b0);
    n_checks++; if (underrun !== 1'b0) $display("FAIL rate_uf_clear: got %b want 0", underrun); else n_pass++;
    n_checks++; if (state !== ST_STARVE) $display("FAIL rate_start_ignored: got %0d want STARVE", state); else n_pass++;
    pulse_stop();
  endtask

  task automatic test_twos_comp();
    logic [27:0] e;
    do_reset();
    push_pair(14'h3FFF, 14'h0000, 1'b1);
    push_pair(14'h2000, 14'h1FFF, 1'b1);
    pulse_start(16'd0, 1'b1);
    repeat (4) tick();
    n_checks++; if (state !== ST_PRIME) $display("FAIL tc_priming: got %0d want PRIME", state); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL tc_prime_active: got %b want 0", active); else n_pass++;
    for (int i = 0; i < 6; i++) push_pair(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b1);
    wait_active();
    n_checks++; if (active !== 1'b1) $display("FAIL tc_prime_timeout: got %b want 1", active); else n_pass++;
    tick();
    n_checks++; if (DA !== 14'h2000) $display("FAIL tc_da_c1: got %h want 2000", DA); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({DA, DB} !== e) $display("FAIL tc_out[%0d]: got %h/%h want %h/%h", k, DA, DB, e[27:14], e[13:0]); else n_pass++;
      if (k == 0) begin
        n_checks++; if (DA !== 14'h1FFF) $display("FAIL tc_minus1: got %h want 1fff", DA); else n_pass++;
      end
      if (k == 1) begin
        n_checks++; if (DA !== 14'h0000) $display("FAIL tc_min: got %h want 0000", DA); else n_pass++;
      end
    end
    pulse_stop();
  endtask

  task automatic test_full();
    int lvl;
    logic [13:0] a;
    logic [27:0] e;
    do_reset();
    lvl = 0;
    for (int i = 0; i < 300; i++) begin
      a = 14'(i);
      bus.s_valid = 1'b1;
      bus.s_data_a = a;
      bus.s_data_b = ~a;
      n_checks++; if (bus.s_ready !== (lvl < DEPTH)) $display("FAIL full_ready[%0d]: got %b want %b", i, bus.s_ready, (lvl < DEPTH)); else n_pass++;
      n_checks++; if (level !== 9'(lvl)) $display("FAIL full_level[%0d]: got %0d want %0d", i, level, lvl); else n_pass++;
      if (lvl < DEPTH) begin
        exp_q.push_back({a, ~a});
        lvl++;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (level !== 9'd256) $display("FAIL full_level_hold: got %0d want 256", level); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL full_ready_low: got %b want 0", bus.s_ready); else n_pass++;
    pulse_start(16'd0, 1'b0);
    tick();
    n_checks++; if (active !== 1'b1) $display("FAIL full_play_entry: got %b want 1", active); else n_pass++;
    tick();
    for (int k = 0; k < 256; k++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({DA, DB} !== e) $display("FAIL full_out[%0d]: got %h/%h want %h/%h", k, DA, DB, e[27:14], e[13:0]); else n_pass++;
    end
    tick();
    n_checks++; if (underrun !== 1'b1) $display("FAIL full_drain_underrun: got %b want 1", underrun); else n_pass++;
    n_checks++; if (level !== 9'd0) $display("FAIL full_drain_level: got %0d want 0", level); else n_pass++;
    pulse_stop();
  endtask

  task automatic test_back_to_back();
    logic [13:0] a;
    logic [27:0] e;
    do_reset();
    for (int i = 0; i < 16; i++) push_pair(14'(i + 100), 14'(i + 200), 1'b0);
    pulse_start(16'd0, 1'b0);
    tick();
    n_checks++; if (active !== 1'b1) $display("FAIL b2b_play_entry: got %b want 1", active); else n_pass++;
    n_checks++; if (level !== 9'd16) $display("FAIL b2b_level_c0: got %0d want 16", level); else n_pass++;
    for (int k = 0; k < 40; k++) begin
      a = 14'($urandom_range(0, 16383));
      bus.s_valid = 1'b1;
      bus.s_data_a = a;
      bus.s_data_b = ~a;
      exp_q.push_back({a, ~a});
      tick();
      n_checks++; if (level !== 9'd16) $display("FAIL b2b_level[%0d]: got %0d want 16", k, level); else n_pass++;
      if (k >= 1) begin
        e = exp_q.pop_front();
        n_checks++; if ({DA, DB} !== e) $display("FAIL b2b_out[%0d]: got %h/%h want %h/%h", k, DA, DB, e[27:14], e[13:0]); else n_pass++;
      end
    end
    bus.s_valid = 1'b0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_checks++; if ({DA, DB} !== e) $display("FAIL b2b_drain: got %h/%h want %h/%h", DA, DB, e[27:14], e[13:0]); else n_pass++;
    end
    pulse_stop();
  endtask

  task automatic test_stop();
    do_reset();
    for (int i = 0; i < 20; i++) push_pair(14'(i + 1000), 14'(i + 3000), 1'b0);
    pulse_start(16'd1, 1'b0);
    wait_active();
    n_checks++; if (active !== 1'b1) $display("FAIL stop_prime_timeout: got %b want 1", active); else n_pass++;
    repeat (5) tick();
    pulse_stop();
    n_checks++; if (DA !== 14'h2000) $display("FAIL stop_da: got %h want 2000", DA); else n_pass++;
    n_checks++; if (DB !== 14'h2000) $display("FAIL stop_db: got %h want 2000", DB); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL stop_active: got %b want 0", active); else n_pass++;
    n_checks++; if (state !== ST_IDLE) $display("FAIL stop_state: got %0d want IDLE", state); else n_pass++;
    n_checks++; if (level !== 9'd17) $display("FAIL stop_fifo_kept: got %0d want 17", level); else n_pass++;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (state !== ST_IDLE) $display("FAIL stop_wins[%0d]: got %0d want IDLE", c, state); else n_pass++;
      n_checks++; if (active !== 1'b0) $display("FAIL stop_wins_active[%0d]: got %b want 0", c, active); else n_pass++;
      tick();
    end
    n_checks++; if (level !== 9'd17) $display("FAIL stop_level_after: got %0d want 17", level); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12; i++) push_pair(14'(i + 5), 14'(i + 9), 1'b0);
    pulse_start(16'd0, 1'b0);
    wait_active();
    n_checks++; if (active !== 1'b1) $display("FAIL rmid_prime_timeout: got %b want 1", active); else n_pass++;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (DA !== 14'h2000) $display("FAIL rmid_da: got %h want 2000", DA); else n_pass++;
    n_checks++; if (DB !== 14'h2000) $display("FAIL rmid_db: got %h want 2000", DB); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL rmid_active: got %b want 0", active); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rmid_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (level !== 9'd0) $display("FAIL rmid_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL rmid_ready: got %b want 0", bus.s_ready); else n_pass++;
    n_checks++; if (state !== ST_IDLE) $display("FAIL rmid_state: got %0d want IDLE", state); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL rmid_ready_rise: got %b want 1", bus.s_ready); else n_pass++;
    n_checks++; if (level !== 9'd0) $display("FAIL rmid_level_after: got %0d want 0", level); else n_pass++;
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data_a = '0;
    bus.s_data_b = '0;
    test_reset();
    test_stream();
    test_rate_div();
    test_twos_comp();
    test_full();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
